// File: rtl/secuenciador_iir_mac.sv
// secuenciador_iir_mac
// Sequencer for a time-multiplexed 2nd-order IIR low-pass datapath. One full
// schedule is run per ADC sample:
//   f_k = Uk + a1*f_k-1 + a2*f_k-2 ; shift ; Yk = b0*f_k + b1*f_k-1 + b2*f_k-2
//
// Ports
//   Clk          system clock, rising edge
//   Reset        asynchronous, active-high
//   Bandera_ADC  new-sample flag; its rising edge requests a schedule
//   Clear_Ovr    synchronous clear of Overrun (a set in the same cycle wins)
//   sel_const    constant mux select (1=a1 2=a2 3=b0 4=b1 5=b2)
//   sel_fun      fk mux select (0=fk 1=fk_1 2=fk_2)
//   sel_acum     adder input (0=Uk 1=accumulator)
//   acum_clr     accumulator loads product with zero addend
//   acum_en      accumulator capture strobe
//   shift_en     fk shift register strobe
//   Band_Listo   Yk valid pulse
//   Busy         schedule in progress (A1..DONE)
//   Overrun      sticky lost-sample flag
//
// Build option: SEQ_IIR_PENDING_EN adds a one-deep pending-sample register so
// that one edge arriving while busy is queued and run back-to-back.
//
// state | meaning
// ------+---------------------------------------------
// IDLE  | waiting for a sample edge
// A1    | acc <= Uk + a1*f_k-1          (HOLD cycles)
// A2    | acc += a2*f_k-2               (HOLD cycles)
// SHIFT | fk shift register advances    (1 cycle)
// B0    | acc <= b0*f_k                 (HOLD cycles)
// B1    | acc += b1*f_k-1               (HOLD cycles)
// B2    | acc += b2*f_k-2               (HOLD cycles)
// DONE  | Yk valid                      (1 cycle)
`timescale 1ns/1ps

module secuenciador_iir_mac #(
    parameter int HOLD    = 2,
    parameter int CONST_W = 3
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Bandera_ADC,
    input  logic               Clear_Ovr,
    output logic [CONST_W-1:0] sel_const,
    output logic [1:0]         sel_fun,
    output logic               sel_acum,
    output logic               acum_clr,
    output logic               acum_en,
    output logic               shift_en,
    output logic               Band_Listo,
    output logic               Busy,
    output logic               Overrun
);

    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_A1, S_A2, S_SHIFT, S_B0, S_B1, S_B2, S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          adc_q;
    logic          adc_edge;
    logic          term_last;
    logic          take_pending;
    logic          overrun_set;

    assign adc_edge  = Bandera_ADC & ~adc_q;
    assign term_last = (cnt == '0);

`ifdef SEQ_IIR_PENDING_EN
    logic pending, pending_nxt;

    always_comb begin
        pending_nxt  = pending;
        overrun_set  = 1'b0;
        take_pending = (state == S_DONE) && pending;
        if (take_pending)
            pending_nxt = 1'b0;
        // The slot is judged on its value at the start of the cycle, so an
        // edge in the DONE cycle that consumes the pending sample is lost.
        if (adc_edge && Busy) begin
            if (pending)
                overrun_set = 1'b1;
            else
                pending_nxt = 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            pending <= 1'b0;
        else
            pending <= pending_nxt;
    end
`else
    assign take_pending = 1'b0;
    assign overrun_set  = adc_edge && Busy;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= S_IDLE;
            cnt     <= CNT_LOAD;
            adc_q   <= 1'b0;
            Overrun <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            adc_q <= Bandera_ADC;
            if (overrun_set)
                Overrun <= 1'b1;
            else if (Clear_Ovr)
                Overrun <= 1'b0;
        end
    end

    // Term states count cnt down to zero and strobe acum_en on the last cycle;
    // every other state parks cnt at the load value so the next term starts full.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = CNT_LOAD;
        sel_const  = '0;
        sel_fun    = 2'd0;
        sel_acum   = 1'b0;
        acum_clr   = 1'b0;
        acum_en    = 1'b0;
        shift_en   = 1'b0;
        Band_Listo = 1'b0;
        Busy       = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (adc_edge)
                    state_nxt = S_A1;
            end
            S_A1: begin
                sel_const = CONST_W'(1);
                sel_fun   = 2'd1;
                acum_en   = term_last;
                if (term_last) state_nxt = S_A2;
                else           cnt_nxt   = cnt - 1'b1;
            end
            S_A2: begin
                sel_const = CONST_W'(2);
                sel_fun   = 2'd2;
                sel_acum  = 1'b1;
                acum_en   = term_last;
                if (term_last) state_nxt = S_SHIFT;
                else           cnt_nxt   = cnt - 1'b1;
            end
            S_SHIFT: begin
                shift_en  = 1'b1;
                state_nxt = S_B0;
            end
            S_B0: begin
                sel_const = CONST_W'(3);
                sel_fun   = 2'd0;
                sel_acum  = 1'b1;
                acum_clr  = 1'b1;
                acum_en   = term_last;
                if (term_last) state_nxt = S_B1;
                else           cnt_nxt   = cnt - 1'b1;
            end
            S_B1: begin
                sel_const = CONST_W'(4);
                sel_fun   = 2'd1;
                sel_acum  = 1'b1;
                acum_en   = term_last;
                if (term_last) state_nxt = S_B2;
                else           cnt_nxt   = cnt - 1'b1;
            end
            S_B2: begin
                sel_const = CONST_W'(5);
                sel_fun   = 2'd2;
                sel_acum  = 1'b1;
                acum_en   = term_last;
                if (term_last) state_nxt = S_DONE;
                else           cnt_nxt   = cnt - 1'b1;
            end
            S_DONE: begin
                Band_Listo = 1'b1;
                state_nxt  = take_pending ? S_A1 : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule
